// File: rtl/cnn_frame_feeder.sv
// Buffers one image from a byte stream, replays it to the CNN as a gap-free burst,
// then times the inference until fc_done or a timeout.
//   state     | meaning
//   ST_FILL   | accepting pixel bytes into the buffer
//   ST_STREAM | replaying the buffer on valid_out/data_out
//   ST_WAIT   | burst done, waiting for fc_done or timeout
module cnn_frame_feeder #(
    parameter int IMG_PIXELS = 784,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 100000,
    parameter int SUB128     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    output logic             valid_out,
    output logic [7:0]       data_out,
    input  logic             fc_done,
    input  logic [3:0]       final_digit,
    output logic             res_valid,
    output logic [3:0]       res_digit,
    output logic [CNT_W-1:0] res_cycles,
    output logic             res_timeout,
    output logic             busy
);
    localparam int              AW      = $clog2(IMG_PIXELS + 1);
    localparam logic [AW-1:0]   LAST_WR = AW'(IMG_PIXELS - 1);
    localparam logic [AW-1:0]   END_RD  = AW'(IMG_PIXELS);
    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
    localparam logic [7:0]      XMASK   = (SUB128 != 0) ? 8'h80 : 8'h00;

    typedef enum logic [1:0] {ST_FILL, ST_STREAM, ST_WAIT} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             res_valid_q, res_valid_d;
    logic [3:0]       res_digit_q, res_digit_d;
    logic [CNT_W-1:0] res_cycles_q, res_cycles_d;
    logic             res_timeout_q, res_timeout_d;

    logic [7:0]       mem_q [IMG_PIXELS];
    logic [7:0]       rd_data_q;
    logic [AW-1:0]    rd_idx;

    // rd_addr_q sits at 0 throughout FILL, so pixel 0 is already latched on entry to STREAM.
    assign rd_idx = (rd_addr_q < END_RD) ? rd_addr_q : '0;

    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_FILL && s_valid) begin
            mem_q[wr_addr_q] <= s_data;
        end
        rd_data_q <= mem_q[rd_idx];
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        cnt_d         = cnt_q;
        res_valid_d   = 1'b0;
        res_digit_d   = res_digit_q;
        res_cycles_d  = res_cycles_q;
        res_timeout_d = res_timeout_q;
        case (state_q)
            ST_FILL: begin
                if (s_valid) begin
                    wr_addr_d = wr_addr_q + AW'(1);
                    if (wr_addr_q == LAST_WR) begin
                        wr_addr_d = '0;
                        rd_addr_d = AW'(1);
                        cnt_d     = '0;
                        state_d   = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                cnt_d = cnt_inc;
                if (rd_addr_q == END_RD) begin
                    rd_addr_d = '0;
                    state_d   = ST_WAIT;
                end else begin
                    rd_addr_d = rd_addr_q + AW'(1);
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                // fc_done takes priority over a simultaneous timeout
                if (fc_done) begin
                    res_digit_d   = final_digit;
                    res_cycles_d  = cnt_q;
                    res_timeout_d = 1'b0;
                    res_valid_d   = 1'b1;
                    state_d       = ST_FILL;
                end else if (cnt_q >= TMO) begin
                    res_digit_d   = 4'hF;
                    res_cycles_d  = TMO;
                    res_timeout_d = 1'b1;
                    res_valid_d   = 1'b1;
                    state_d       = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FILL;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            cnt_q         <= '0;
            res_valid_q   <= 1'b0;
            res_digit_q   <= '0;
            res_cycles_q  <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            cnt_q         <= cnt_d;
            res_valid_q   <= res_valid_d;
            res_digit_q   <= res_digit_d;
            res_cycles_q  <= res_cycles_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign s_ready     = (state_q == ST_FILL);
    assign valid_out   = (state_q == ST_STREAM);
    assign data_out    = valid_out ? (rd_data_q ^ XMASK) : 8'h00;
    assign busy        = (state_q == ST_STREAM) || (state_q == ST_WAIT);
    assign res_valid   = res_valid_q;
    assign res_digit   = res_digit_q;
    assign res_cycles  = res_cycles_q;
    assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_cnn_frame_feeder.sv
// Directed bench: two feeders (pass-through and SUB128) driven from the same stimulus.
module tb_cnn_frame_feeder;
    localparam int IMG = 784;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        fc_done;
    logic [3:0]  final_digit;

    logic        s_ready, valid_out, res_valid, res_timeout, busy;
    logic [7:0]  data_out;
    logic [3:0]  res_digit;
    logic [31:0] res_cycles;

    logic        s_ready_b, valid_b, res_valid_b, res_timeout_b, busy_b;
    logic [7:0]  data_b;
    logic [3:0]  res_digit_b;
    logic [31:0] res_cycles_b;

    int n_chk = 0;
    int n_bad = 0;

    cnn_frame_feeder #(.IMG_PIXELS(IMG), .CNT_W(32), .TIMEOUT(2000), .SUB128(0)) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .valid_out(valid_out), .data_out(data_out), .fc_done(fc_done),
        .final_digit(final_digit), .res_valid(res_valid), .res_digit(res_digit),
        .res_cycles(res_cycles), .res_timeout(res_timeout), .busy(busy)
    );

    cnn_frame_feeder #(.IMG_PIXELS(IMG), .CNT_W(32), .TIMEOUT(2000), .SUB128(1)) u_sub (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
        .valid_out(valid_b), .data_out(data_b), .fc_done(fc_done),
        .final_digit(final_digit), .res_valid(res_valid_b), .res_digit(res_digit_b),
        .res_cycles(res_cycles_b), .res_timeout(res_timeout_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int k, input int mode);
        int r;
        if (mode == 0) return k[7:0];
        r = k % 3;
        if (r == 0) return 8'h00;
        if (r == 1) return 8'h80;
        return 8'hFF;
    endfunction

    // Returns at the negedge of the first STREAM cycle (T0).
    task automatic send_frame(input int duty, input int mode, input bit offer_extra);
        int k;
        int guard;
        k = 0;
        guard = 0;
        while (k < IMG && guard < 20000) begin
            if ($urandom_range(99) < duty) begin
                s_valid = 1'b1;
                s_data  = pat(k, mode);
                k++;
            end else begin
                s_valid = 1'b0;
                s_data  = 8'h5A;
            end
            @(negedge clk);
            guard++;
        end
        chk("fill_count", k, IMG);
        s_valid = offer_extra;
        s_data  = 8'hAA;
    endtask

    // Starts at T0, returns at the negedge of the first WAIT cycle (T0+IMG).
    task automatic collect(input int mode);
        int len;
        int errs;
        len = 0;
        errs = 0;
        chk("s_ready_low", s_ready, 0);
        chk("busy_stream", busy, 1);
        while (valid_out && len < 2 * IMG) begin
            if (data_out !== pat(len, mode)) errs++;
            if (valid_b !== 1'b1 || data_b !== (pat(len, mode) ^ 8'h80)) errs++;
            len++;
            @(negedge clk);
            s_valid = 1'b0;
        end
        chk("burst_len", len, IMG);
        chk("burst_data_errs", errs, 0);
        chk("post_burst_data", data_out, 0);
        chk("busy_wait", busy, 1);
    endtask

    task automatic wait_res(input int bound, output int n);
        n = 0;
        while (!res_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = 8'h00;
        fc_done = 1'b0;
        final_digit = 4'h0;

        @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // partial frame, then reset: the partial bytes must be discarded
        for (int k = 0; k < 100; k++) begin
            s_valid = 1'b1;
            s_data  = 8'hC3;
            @(negedge clk);
        end
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_s_ready", s_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_res_cycles", res_cycles, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // contiguous frame, fc_done exactly 1000 cycles after T0
        send_frame(100, 0, 1'b0);
        collect(0);
        repeat (1000 - IMG) @(negedge clk);
        fc_done = 1'b1;
        final_digit = 4'd7;
        @(negedge clk);
        fc_done = 1'b0;
        final_digit = 4'd0;
        chk("res_valid_a", res_valid, 1);
        chk("res_digit_a", res_digit, 7);
        chk("res_cycles_a", res_cycles, 1000);
        chk("res_timeout_a", res_timeout, 0);
        chk("refill_ready", s_ready, 1);
        chk("idle_busy", busy, 0);
        @(negedge clk);
        chk("res_pulse_a", res_valid, 0);
        chk("res_hold_a", res_digit, 7);

        // gappy frame; extra byte offered at T0; fc_done held from T0 is ignored until WAIT
        send_frame(30, 0, 1'b1);
        fc_done = 1'b1;
        final_digit = 4'd5;
        collect(0);
        chk("no_early_res", res_valid, 0);
        @(negedge clk);
        fc_done = 1'b0;
        chk("res_valid_b", res_valid, 1);
        chk("res_digit_b", res_digit, 5);
        chk("res_cycles_b", res_cycles, IMG);

        // timeout: no fc_done at all
        @(negedge clk);
        send_frame(100, 0, 1'b0);
        collect(0);
        wait_res(3000, n);
        chk("tmo_latency", n, 2001 - IMG);
        chk("tmo_digit", res_digit, 4'hF);
        chk("tmo_cycles", res_cycles, 2000);
        chk("tmo_flag", res_timeout, 1);
        chk("tmo_s_ready", s_ready, 1);
        @(negedge clk);
        chk("tmo_pulse", res_valid, 0);

        // fc_done on the timeout cycle counts as a normal completion
        send_frame(100, 0, 1'b0);
        collect(0);
        repeat (2000 - IMG) @(negedge clk);
        fc_done = 1'b1;
        final_digit = 4'd3;
        @(negedge clk);
        fc_done = 1'b0;
        chk("tie_valid", res_valid, 1);
        chk("tie_digit", res_digit, 3);
        chk("tie_cycles", res_cycles, 2000);
        chk("tie_timeout", res_timeout, 0);

        // SUB128 offset, then reset at pixel 300 of the burst
        send_frame(100, 1, 1'b0);
        chk("sub_px0", data_b, 8'h80);
        chk("raw_px0", data_out, 8'h00);
        @(negedge clk);
        chk("sub_px1", data_b, 8'h00);
        @(negedge clk);
        chk("sub_px2", data_b, 8'h7F);
        chk("raw_px2", data_out, 8'hFF);
        repeat (298) @(negedge clk);
        chk("sub_px300", data_b, 8'h80);
        chk("valid_px300", valid_b, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("strst_valid", valid_out, 0);
        chk("strst_valid_sub", valid_b, 0);
        chk("strst_data_sub", data_b, 0);
        chk("strst_s_ready", s_ready, 1);
        chk("strst_busy", busy, 0);
        chk("strst_res_cycles", res_cycles, 0);
        chk("strst_res_digit", res_digit, 0);
        chk("strst_res_timeout", res_timeout, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        send_frame(100, 1, 1'b0);
        chk("sub2_px0", data_b, 8'h80);
        collect(1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
